fixed_mult_pipe: RTL and testbench

Pipelined, parametrised signed fixed-point multiplier with valid/ready handshaking, runtime rounding and saturation modes, and per-result plus sticky overflow/underflow flags. It is the streaming replacement for the combinational Q24.8 multiplier in the gradient-descent datapath, where the parameter-update and gradient-scaling stages sit. At defaults it computes the same Q24.8 product, but it is registered, back-pressurable and configurable in width and fraction.

---
 rtl/fixed_pkg.sv | 29 ++
 rtl/fixed_round_sat.sv | 50 +++++
 rtl/fixed_mult_pipe.sv | 165 ++++++++++++++++
 tb/tb_fixed_mult_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared constants, per-operand mode bundle and saturation-limit helpers for the fixed-point datapath.
// Consumed by the multiplier pipe and the round/saturate slice.
package fixed_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_FRAC_BITS = 8;

  localparam logic ROUND_TRUNC   = 1'b0;
  localparam logic ROUND_HALF_UP = 1'b1;

  // Upper bound on any WIDTH these helpers are asked about.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic round_mode;
    logic sat_en;
  } mode_t;

  // Largest positive two's-complement value at width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Most negative value at width w, sign-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rounding, rescaling and range check of a 2*WIDTH signed product; no latency, no handshake.
// Output is saturated or wrapped per sat_en; the flags are raised whenever the result is out of range.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic               round_mode,
  input  logic               sat_en,
  output logic [WIDTH-1:0]   p,
  output logic               ovf,
  output logic               unf
);

  localparam int PW = 2 * WIDTH;
  localparam int QW = PW - FRAC_BITS;

  localparam logic [WIDTH-1:0] P_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] P_MIN = WIDTH'(sat_min(WIDTH));
  localparam logic [PW-1:0]    HALF  = PW'(1) << (FRAC_BITS - 1);

  logic [PW-1:0]      rnd;
  logic [QW-1:0]      q;
  logic [QW-WIDTH:0]  top;
  logic               in_range;
  logic               unused_frac;

  always_comb begin
    // The largest |product| is 2^(PW-2), so adding HALF cannot wrap.
    rnd = prod + ((round_mode == ROUND_HALF_UP) ? HALF : '0);
    // Dropping the low bits of the 2's-complement sum is the arithmetic shift.
    q           = rnd[PW-1:FRAC_BITS];
    unused_frac = ^rnd[FRAC_BITS-1:0];

    top      = q[QW-1:WIDTH-1];
    in_range = (&top) || (~|top);
    ovf      = !in_range && !q[QW-1];
    unf      = !in_range && q[QW-1];

    p = q[WIDTH-1:0];
    if (sat_en && ovf) begin
      p = P_MAX;
    end else if (sat_en && unf) begin
      p = P_MIN;
    end
  end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Signed fixed-point multiplier, 3-stage pipe (operands -> product -> rounded result); 3-cycle latency, 1/cycle.
// Bubble-collapsing valid/ready: each stage loads when empty or when its successor moves; in_ready follows out_ready.
module fixed_mult_pipe
  import fixed_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             round_mode,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             ovf,
  output logic             unf,
  output logic             sticky_ovf,
  output logic             sticky_unf,
  input  logic             clr_flags
);

  localparam int PW = 2 * WIDTH;

  // Stage 1: operands and their modes
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  mode_t            mode1_q, mode1_d;

  // Stage 2: full-width product
  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    prod_q, prod_d;
  mode_t            mode2_q, mode2_d;

  // Stage 3: visible result
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             sticky_unf_q, sticky_unf_d;

  logic             s1_adv, s2_adv, s3_adv;
  logic             handoff;
  logic signed [PW-1:0] a_ext, b_ext;

  logic [WIDTH-1:0] rs_p;
  logic             rs_ovf, rs_unf;

  fixed_round_sat #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .prod       (prod_q),
    .round_mode (mode2_q.round_mode),
    .sat_en     (mode2_q.sat_en),
    .p          (rs_p),
    .ovf        (rs_ovf),
    .unf        (rs_unf)
  );

  always_comb begin
    s3_adv  = !out_valid_q || out_ready;
    s2_adv  = !s2_valid_q || s3_adv;
    s1_adv  = !s1_valid_q || s2_adv;
    handoff = out_valid_q && out_ready;

    a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};

    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    mode1_d     = mode1_q;
    s2_valid_d  = s2_valid_q;
    prod_d      = prod_q;
    mode2_d     = mode2_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;

    if (s1_adv) begin
      s1_valid_d         = in_valid;
      a_d                = a_in;
      b_d                = b_in;
      mode1_d.round_mode = round_mode;
      mode1_d.sat_en     = sat_en;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      prod_d     = a_ext * b_ext;
      mode2_d    = mode1_q;
    end

    // Result registers only reload with a real result, so a held output stays put.
    if (s3_adv) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        p_d   = rs_p;
        ovf_d = rs_ovf;
        unf_d = rs_unf;
      end
    end

    // A flag being handed off outranks a simultaneous clear.
    sticky_ovf_d = sticky_ovf_q;
    sticky_unf_d = sticky_unf_q;
    if (clr_flags) begin
      sticky_ovf_d = 1'b0;
      sticky_unf_d = 1'b0;
    end
    if (handoff && ovf_q) begin
      sticky_ovf_d = 1'b1;
    end
    if (handoff && unf_q) begin
      sticky_unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      p_q          <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      out_valid_q  <= out_valid_d;
      p_q          <= p_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    mode1_q <= mode1_d;
    prod_q  <= prod_d;
    mode2_q <= mode2_d;
  end

  assign in_ready   = s1_adv;
  assign out_valid  = out_valid_q;
  assign p_out      = p_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Scoreboard bench for fixed_mult_pipe at Q24.8: directed corner cases, capacity, sticky flags,
// a randomly back-pressured stream and a mid-stream reset.
module tb_fixed_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in, b_in;
  logic        round_mode, sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p_out;
  logic        ovf, unf, sticky_ovf, sticky_unf;
  logic        clr_flags;

  always #5 clk = ~clk;

  fixed_mult_pipe #(.WIDTH(32), .FRAC_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .round_mode (round_mode),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p_out      (p_out),
    .ovf        (ovf),
    .unf        (unf),
    .sticky_ovf (sticky_ovf),
    .sticky_unf (sticky_unf),
    .clr_flags  (clr_flags)
  );

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden model: exact 64-bit arithmetic, range judged numerically.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic rm, input logic sat);
    exp_t   e;
    longint pa, pb, prod, q;
    pa   = longint'($signed(a));
    pb   = longint'($signed(b));
    prod = pa * pb;
    if (rm) prod = prod + 128;
    q     = prod >>> 8;
    e.ovf = (q > 64'sd2147483647);
    e.unf = (q < -64'sd2147483648);
    e.p   = q[31:0];
    if (sat && e.ovf) e.p = 32'h7FFF_FFFF;
    if (sat && e.unf) e.p = 32'h8000_0000;
    return e;
  endfunction

  // Monitor: everything sampled on the falling edge; transfers take effect on the next rising edge.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_p;
  logic        prev_ovf, prev_unf;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_model", in_ready, !(sb.size() == 3 && !out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_p", p_out, prev_p);
        check("stall_flags", {ovf, unf}, {prev_ovf, prev_unf});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("sb_p", p_out, e.p);
          check("sb_flags", {ovf, unf}, {e.ovf, e.unf});
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a_in, b_in, round_mode, sat_en));
      prev_stall = out_valid && !out_ready;
      prev_p     = p_out;
      prev_ovf   = ovf;
      prev_unf   = unf;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic sat);
    bit acc = 0;
    in_valid   = 1'b1;
    a_in       = a;
    b_in       = b;
    round_mode = rm;
    sat_en     = sat;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        break;
      end
    end
    if (!acc) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] da[7], db[7];
  logic        drm[7], dsat[7];
  bit          stream_done;

  initial begin
    da[0] = 32'h0000_0001; db[0] = 32'h0000_0080; drm[0] = 0; dsat[0] = 0;
    da[1] = 32'h0000_0001; db[1] = 32'h0000_0080; drm[1] = 1; dsat[1] = 0;
    da[2] = 32'hFFFF_FFFF; db[2] = 32'h0000_0080; drm[2] = 0; dsat[2] = 0;
    da[3] = 32'hFFFF_FFFF; db[3] = 32'h0000_0080; drm[3] = 1; dsat[3] = 0;
    da[4] = 32'h7FFF_FFFF; db[4] = 32'h0000_0200; drm[4] = 0; dsat[4] = 1;
    da[5] = 32'h7FFF_FFFF; db[5] = 32'h0000_0200; drm[5] = 0; dsat[5] = 0;
    da[6] = 32'h8000_0000; db[6] = 32'h0000_0200; drm[6] = 0; dsat[6] = 1;

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
    round_mode = 1'b0; sat_en = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_p_out", p_out, 0);
    check("rst_flags", {ovf, unf, sticky_ovf, sticky_unf}, 0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // Basic Q24.8 product and pipeline latency: 1.5 * 2.0 = 3.0.
    in_valid = 1'b1; a_in = 32'h0000_0180; b_in = 32'h0000_0200;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_out_valid", out_valid, 1);
    check("basic_p", p_out, 32'h0000_0300);
    check("basic_flags", {ovf, unf}, 0);
    wait_drain();

    // Rounding and saturation corners, checked through the scoreboard plus the literal values.
    for (int i = 0; i < 7; i++) begin
      send(da[i], db[i], drm[i], dsat[i]);
      wait_drain();
    end
    check("sticky_ovf_after_sat", sticky_ovf, 1);
    check("sticky_unf_after_neg", sticky_unf, 1);
    check("model_neg_limit", model(da[6], db[6], 0, 1).p, 32'h8000_0000);
    check("model_wrap", model(da[5], db[5], 0, 0).p, 32'hFFFF_FFFE);
    check("model_rnd_neg", model(da[3], db[3], 1, 0).p, 32'h0000_0000);

    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    check("clr_sticky", {sticky_ovf, sticky_unf}, 0);

    // Clear collides with an overflow hand-off: the set must win.
    out_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h0000_0200, 0, 1);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    check("clr_race_valid", out_valid, 1);
    out_ready = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    check("clr_race_sticky", sticky_ovf, 1);
    wait_drain();

    // Capacity: three held with out_ready low, the fourth is refused.
    out_ready = 1'b0;
    send(32'h0000_0100, 32'h0000_0300, 0, 0);
    send(32'hFFFF_FE00, 32'h0000_0280, 1, 0);
    send(32'h0012_3456, 32'hFFF0_0000, 0, 1);
    check("cap_full", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h0000_0040, 32'h0000_0040, 1, 1);
    wait_drain();

    // Random stream under random back-pressure.
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [31:0] ra, rb;
          ra = $urandom;
          rb = $urandom;
          if (i % 3 != 0) begin
            ra = {{16{ra[15]}}, ra[15:0]};
            rb = {{16{rb[15]}}, rb[15:0]};
          end
          send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with transactions in flight: nothing may come out afterwards.
    out_ready = 1'b0;
    send(32'h0000_0500, 32'h0000_0500, 0, 0);
    send(32'h0000_0600, 32'h0000_0600, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_quiet", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
